// File: rtl/frontend_command_definition_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : frontend_command_definition_pkg                            |
// | Brief   : Shared front-end command types (core-number tag).          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package frontend_command_definition_pkg;

    localparam int CORE_NUM_W = 2;

    typedef logic [CORE_NUM_W-1:0] core_num_t;

endpackage : frontend_command_definition_pkg
`default_nettype wire

// File: rtl/core_num_fifo_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : core_num_fifo_ch                                           |
// | Brief   : One in-order core-number queue with count, flags, masking. |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module core_num_fifo_ch
    import frontend_command_definition_pkg::*;
#(
    parameter int DATA_WIDTH = CORE_NUM_W,
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL_TH   = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_rd_en,
    input  logic                  i_flush,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_afull,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_ovf,
    output logic                  o_udf
);

    localparam int                c_DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_AFULL = (DEPTH_LOG2+1)'(AFULL_TH);
    localparam logic [DEPTH_LOG2:0] c_ONE   = (DEPTH_LOG2+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DEPTH_LOG2:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_afull;

    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH_LOG2:0]   w_wr_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_rd_ptr_nxt;
    logic [DEPTH_LOG2:0]   w_count_nxt;
    logic                  w_full_nxt;

    // A full queue still accepts a push when the head is popped the same cycle.
    always_comb begin
        w_push       = i_wr_en && !i_flush && (!r_full || i_rd_en);
        w_pop        = i_rd_en && !i_flush && !r_empty;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        if (i_flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end else begin
            if (w_push) w_wr_ptr_nxt = r_wr_ptr + c_ONE;
            if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + c_ONE;
        end
        w_count_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_full_nxt  = (w_wr_ptr_nxt[DEPTH_LOG2-1:0] == w_rd_ptr_nxt[DEPTH_LOG2-1:0])
                   && (w_wr_ptr_nxt[DEPTH_LOG2] != w_rd_ptr_nxt[DEPTH_LOG2]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full   <= w_full_nxt;
            r_afull  <= (w_count_nxt >= c_AFULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
    end

    // Storage is never cleared, so stale contents are hidden while empty.
    assign o_data  = r_empty ? '0 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
    assign o_empty = r_empty;
    assign o_full  = r_full;
    assign o_afull = r_afull;
    assign o_count = r_count;
    assign o_ovf   = i_wr_en && !i_flush && r_full && !i_rd_en;
    assign o_udf   = i_rd_en && !i_flush && r_empty;

endmodule : core_num_fifo_ch
`default_nettype wire

// File: rtl/read_core_num_mc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : read_core_num_mc_fifo                                      |
// | Brief   : Per-DRAM-channel core-number queues with sticky misuse flags|
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module read_core_num_mc_fifo
    import frontend_command_definition_pkg::*;
#(
    parameter int DATA_WIDTH = CORE_NUM_W,
    parameter int NUM_CH     = 4,
    parameter int DEPTH_LOG2 = 4,
    parameter int AFULL_TH   = 12
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic                                i_wr_en,
    input  logic [$clog2(NUM_CH)-1:0]           i_wr_ch,
    input  logic [DATA_WIDTH-1:0]               i_data,
    input  logic [NUM_CH-1:0]                   i_rd_en,
    input  logic [NUM_CH-1:0]                   i_flush,
    output logic [NUM_CH*DATA_WIDTH-1:0]        o_data,
    output logic [NUM_CH-1:0]                   o_empty,
    output logic [NUM_CH-1:0]                   o_full,
    output logic [NUM_CH-1:0]                   o_afull,
    output logic [NUM_CH*(DEPTH_LOG2+1)-1:0]    o_count,
    output logic                                o_ovf_err,
    output logic                                o_udf_err
);

    localparam int c_CH_W  = $clog2(NUM_CH);
    localparam int c_CNT_W = DEPTH_LOG2 + 1;

    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_udf;
    logic              w_bad_ch;
    logic              r_ovf_err;
    logic              r_udf_err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [c_CH_W-1:0] c_IDX = c_CH_W'(c);

        assign w_wr_en[c] = i_wr_en && (i_wr_ch == c_IDX);

        core_num_fifo_ch #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2),
            .AFULL_TH   (AFULL_TH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_wr_en (w_wr_en[c]),
            .i_data  (i_data),
            .i_rd_en (i_rd_en[c]),
            .i_flush (i_flush[c]),
            .o_data  (o_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_empty (o_empty[c]),
            .o_full  (o_full[c]),
            .o_afull (o_afull[c]),
            .o_count (o_count[c*c_CNT_W +: c_CNT_W]),
            .o_ovf   (w_ovf[c]),
            .o_udf   (w_udf[c])
        );
    end

    // Channel codes beyond NUM_CH only exist when NUM_CH is not a power of two.
    if ((1 << c_CH_W) != NUM_CH) begin : g_bad_ch
        assign w_bad_ch = i_wr_en && (i_wr_ch >= c_CH_W'(NUM_CH));
    end else begin : g_no_bad_ch
        assign w_bad_ch = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            r_ovf_err <= r_ovf_err | (|w_ovf) | w_bad_ch;
            r_udf_err <= r_udf_err | (|w_udf);
        end
    end

    assign o_ovf_err = r_ovf_err;
    assign o_udf_err = r_udf_err;

endmodule : read_core_num_mc_fifo
`default_nettype wire

// File: tb/tb_read_core_num_mc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_read_core_num_mc_fifo                                   |
// | Brief   : Queue-model checked bench for read_core_num_mc_fifo.       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_read_core_num_mc_fifo;

    localparam int NCH = 4;
    localparam int DL  = 4;
    localparam int DEP = 16;
    localparam int AF  = 12;
    localparam int CW  = DL + 1;

    logic               clk = 1'b0;
    logic               i_rst = 1'b0;
    logic               i_wr_en = 1'b0;
    logic [1:0]         i_wr_ch = '0;
    logic [1:0]         i_data = '0;
    logic [NCH-1:0]     i_rd_en = '0;
    logic [NCH-1:0]     i_flush = '0;
    logic [NCH*2-1:0]   o_data;
    logic [NCH-1:0]     o_empty;
    logic [NCH-1:0]     o_full;
    logic [NCH-1:0]     o_afull;
    logic [NCH*CW-1:0]  o_count;
    logic               o_ovf_err;
    logic               o_udf_err;

    always #5 clk = ~clk;

    read_core_num_mc_fifo #(
        .DATA_WIDTH (2),
        .NUM_CH     (NCH),
        .DEPTH_LOG2 (DL),
        .AFULL_TH   (AF)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_wr_en   (i_wr_en),
        .i_wr_ch   (i_wr_ch),
        .i_data    (i_data),
        .i_rd_en   (i_rd_en),
        .i_flush   (i_flush),
        .o_data    (o_data),
        .o_empty   (o_empty),
        .o_full    (o_full),
        .o_afull   (o_afull),
        .o_count   (o_count),
        .o_ovf_err (o_ovf_err),
        .o_udf_err (o_udf_err)
    );

    int  vectors     = 0;
    int  miscompares = 0;
    bit  chk_en      = 1'b0;

    logic [1:0] mq [NCH][$];
    bit         m_ovf;
    bit         m_udf;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [CW-1:0] cnt(int c);
        return o_count[c*CW +: CW];
    endfunction

    function automatic logic [1:0] dat(int c);
        return o_data[c*2 +: 2];
    endfunction

    // Queue-level model: flush wins, then pop from the head, then append at the tail.
    function automatic void model_step(bit rst, bit wr, int ch, logic [1:0] d,
                                       logic [NCH-1:0] rd, logic [NCH-1:0] fl);
        if (rst) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            return;
        end
        for (int c = 0; c < NCH; c++) begin
            int n;
            bit tgt;
            n   = mq[c].size();
            tgt = wr && (ch == c);
            if (fl[c]) begin
                mq[c].delete();
                continue;
            end
            if (rd[c] && n == 0) m_udf = 1'b1;
            if (tgt && n == DEP && !rd[c]) m_ovf = 1'b1;
            if (rd[c] && n > 0) void'(mq[c].pop_front());
            if (tgt && (n < DEP || rd[c])) mq[c].push_back(d);
        end
    endfunction

    task automatic cyc(bit rst, bit wr, int ch, logic [1:0] d,
                       logic [NCH-1:0] rd, logic [NCH-1:0] fl);
        i_rst   = rst;
        i_wr_en = wr;
        i_wr_ch = 2'(ch);
        i_data  = d;
        i_rd_en = rd;
        i_flush = fl;
        @(posedge clk);
        model_step(rst, wr, ch, d, rd, fl);
        #1;
        i_rst   = 1'b0;
        i_wr_en = 1'b0;
        i_rd_en = '0;
        i_flush = '0;
    endtask

    task automatic chk_reset_state();
        chk("rst_empty", o_empty, 4'hF);
        chk("rst_full",  o_full,  4'h0);
        chk("rst_afull", o_afull, 4'h0);
        chk("rst_count", o_count, '0);
        chk("rst_data",  o_data,  '0);
        chk("rst_ovf",   o_ovf_err, 1'b0);
        chk("rst_udf",   o_udf_err, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [NCH*2-1:0]  ed;
        logic [NCH*CW-1:0] ec;
        logic [NCH-1:0]    ee, ef, ea;
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                ed[c*2 +: 2]   = (mq[c].size() > 0) ? mq[c][0] : 2'd0;
                ec[c*CW +: CW] = CW'(mq[c].size());
                ee[c]          = (mq[c].size() == 0);
                ef[c]          = (mq[c].size() == DEP);
                ea[c]          = (mq[c].size() >= AF);
            end
            chk("cmp_data",  o_data,  ed);
            chk("cmp_count", o_count, ec);
            chk("cmp_empty", o_empty, ee);
            chk("cmp_full",  o_full,  ef);
            chk("cmp_afull", o_afull, ea);
            chk("cmp_ovf",   o_ovf_err, m_ovf);
            chk("cmp_udf",   o_udf_err, m_udf);
        end
    end

    initial begin
        cyc(1, 0, 0, 0, '0, '0);
        chk_en = 1'b1;
        chk_reset_state();

        // In-order delivery on ch1.
        cyc(0, 1, 1, 2'd2, '0, '0);
        chk("ch1_cnt1", cnt(1), 1);
        chk("ch1_head", dat(1), 2);
        cyc(0, 1, 1, 2'd1, '0, '0);
        chk("ch1_cnt2", cnt(1), 2);
        cyc(0, 1, 1, 2'd3, '0, '0);
        chk("ch1_cnt3", cnt(1), 3);
        chk("ch1_head_still", dat(1), 2);
        cyc(0, 0, 0, 0, 4'b0010, '0);
        chk("ch1_pop1_cnt", cnt(1), 2);
        chk("ch1_pop1_data", dat(1), 1);
        cyc(0, 0, 0, 0, 4'b0010, '0);
        chk("ch1_pop2_data", dat(1), 3);
        cyc(0, 0, 0, 0, 4'b0010, '0);
        chk("ch1_pop3_cnt", cnt(1), 0);
        chk("ch1_pop3_data", dat(1), 0);
        chk("all_empty", o_empty, 4'hF);

        // Fill ch0, overflow, then write-through while full.
        for (int i = 0; i < DEP; i++) begin
            cyc(0, 1, 0, 2'(i), '0, '0);
            if (i == AF - 2) chk("afull_below", o_afull[0], 1'b0);
            if (i == AF - 1) chk("afull_at_th", o_afull[0], 1'b1);
        end
        chk("ch0_full", o_full[0], 1'b1);
        chk("ch0_cnt16", cnt(0), 16);
        cyc(0, 1, 0, 2'd2, '0, '0);
        chk("ovf_set", o_ovf_err, 1'b1);
        chk("ovf_cnt", cnt(0), 16);
        cyc(0, 1, 0, 2'd3, 4'b0001, '0);
        chk("wt_cnt", cnt(0), 16);
        chk("wt_head", dat(0), 1);
        for (int i = 0; i < DEP - 1; i++) cyc(0, 0, 0, 0, 4'b0001, '0);
        chk("wt_tail", dat(0), 3);
        chk("wt_tail_cnt", cnt(0), 1);
        cyc(0, 0, 0, 0, 4'b0001, '0);

        // Underflow on ch2, then push+pop on empty.
        cyc(0, 0, 0, 0, 4'b0100, '0);
        chk("udf_set", o_udf_err, 1'b1);
        chk("udf_cnt", cnt(2), 0);
        cyc(0, 1, 2, 2'd1, 4'b0100, '0);
        chk("pp_empty_cnt", cnt(2), 1);
        chk("pp_empty_data", dat(2), 1);
        cyc(0, 0, 0, 0, 4'b0100, '0);

        // Flush with same-cycle push on ch3.
        cyc(1, 0, 0, 0, '0, '0);
        chk_reset_state();
        for (int i = 0; i < 5; i++) cyc(0, 1, 3, 2'(i + 1), '0, '0);
        chk("ch3_cnt5", cnt(3), 5);
        cyc(0, 1, 3, 2'd2, 4'b1000, 4'b1000);
        chk("flush_cnt", cnt(3), 0);
        chk("flush_empty", o_empty[3], 1'b1);
        chk("flush_ovf", o_ovf_err, 1'b0);
        chk("flush_udf", o_udf_err, 1'b0);

        // Streaming on ch1 across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            int  n;
            bit  wr;
            bit  rd;
            n  = mq[1].size();
            wr = (n < DEP) && ($urandom_range(0, 3) != 0);
            rd = (n > 0) && (($urandom_range(0, 2) == 0) || n >= AF);
            cyc(0, wr, 1, 2'($urandom), {2'b00, rd, 1'b0}, '0);
        end

        // Unconstrained random traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            bit rst;
            rst = ($urandom_range(0, 49) == 0);
            cyc(rst, $urandom_range(0, 1) == 1, $urandom_range(0, NCH - 1), 2'($urandom),
                4'($urandom & $urandom),
                ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0);
            if (rst) chk_reset_state();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_read_core_num_mc_fifo
`default_nettype wire

// File: doc/read_core_num_mc_fifo.md
# read_core_num_mc_fifo

Multi-channel, parametrised successor to the single-queue read core-number FIFO. It holds one independent in-order queue of `core_num_t` tags per DRAM channel. The read-issue path pushes the requesting core number into the queue of the target channel; each channel's read-return path pops its own queue to route returning data to the right core. Beyond a plain FIFO, it adds per-channel occupancy, an almost-full flag, flush, write-through-when-full on same-cycle pop, and sticky misuse error flags.

## Interface
Parameters:
- `DATA_WIDTH`, 2: tag width; equals `$bits(core_num_t)`.
- `NUM_CH`, 4: number of independent queues, ≥2.
- `DEPTH_LOG2`, 4: log2 of per-channel depth (16 entries).
- `AFULL_TH`, 12: occupancy at or above which `o_afull` asserts, 1..2^DEPTH_LOG2.

Ports (`CH_W = $clog2(NUM_CH)`, `CNT_W = DEPTH_LOG2+1`):
- `i_clk` input 1: clock; all logic on rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_wr_en` input 1: push request.
- `i_wr_ch` input CH_W: target channel of the push.
- `i_data` input DATA_WIDTH: tag to push.
- `i_rd_en` input NUM_CH: per-channel pop request.
- `i_flush` input NUM_CH: per-channel queue clear.
- `o_data` output NUM_CH×DATA_WIDTH: per-channel head tag, show-ahead.
- `o_empty` output NUM_CH: channel empty.
- `o_full` output NUM_CH: channel full.
- `o_afull` output NUM_CH: occupancy ≥ AFULL_TH.
- `o_count` output NUM_CH×CNT_W: per-channel occupancy 0..2^DEPTH_LOG2.
- `o_ovf_err` output 1: sticky; push rejected because channel full.
- `o_udf_err` output 1: sticky; pop requested on empty channel.

## Operation
- Each channel has its own storage, and its own `wr_ptr`/`rd_ptr` of width DEPTH_LOG2+1 with a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ.
- `o_count` = `wr_ptr - rd_ptr` (modulo 2^CNT_W). It is registered, together with `o_empty`, `o_full` and `o_afull`, all computed from the next-state pointers.
- Push accepted on channel c when `i_wr_en`, `i_wr_ch==c`, `!i_flush[c]`, and either `!o_full[c]` or (`o_full[c]` and `i_rd_en[c]`).
- This write-through-when-full case is new behaviour: count stays at full, and both pointers advance.
- Pop accepted on channel c when `i_rd_en[c]`, `!o_empty[c]` and `!i_flush[c]`.
- A push to an empty channel with a same-cycle pop: the pop is rejected, the push is accepted, and count becomes 1.
- `o_data[c]` = `mem[c][rd_ptr]` when `!o_empty[c]`, else 0. The head is valid in the same cycle `o_empty` falls; a pop consumes it at the clock edge.
- Flush on channel c: both pointers go to 0 and count goes to 0 next cycle. Any push or pop to c in the same cycle is ignored and does not set error flags.
- Error flags:
  - `o_ovf_err` sets when `i_wr_en` targets a full, non-flushing channel without a same-cycle pop on that channel.
  - `o_udf_err` sets on any `i_rd_en[c]` to an empty, non-flushing channel.
  - Both flags clear only on reset.
- `i_wr_ch ≥ NUM_CH` (non-power-of-two NUM_CH): push dropped and `o_ovf_err` set.
- Storage contents are not reset. Correctness relies on the masking of `o_data` when empty.

## Timing
- Reset, taking effect at the first rising edge with `i_rst`=1:
  - all pointers 0; `o_empty`=all 1s; `o_full`, `o_afull`=0; `o_count`=0; `o_data`=0; both error flags 0.
  - `i_rst` overrides flush, push and pop in the same cycle. Reset mid-operation discards all queued tags.
- Push-to-visible latency: 1 cycle. A tag pushed at edge N appears on `o_data`, with `o_empty` low, after edge N.
- Pop latency: 0. The head is consumed at the edge, and the next entry is visible after that edge.
- Status flags update 1 cycle after the accepted operation; they never lag the pointers.
- Pointer wrap: low bits roll 2^DEPTH_LOG2−1→0 and the wrap bit toggles. No other discontinuity.
- Channels are fully independent. Pops on all NUM_CH channels and one push can all complete in the same cycle.

## Structure
- Shared package `frontend_command_definition_pkg`: `core_num_t` and constant `CORE_NUM_W` (2).
- Sub-module `core_num_fifo_ch`: one queue with pointers, count, flags, head masking, and local ovf/udf pulses.
  - Instantiated NUM_CH times by generate.
  - Top level handles channel decode, and ORs the error pulses into the sticky registers.

## Test plan
- Reset with NUM_CH=4, DEPTH_LOG2=4 → all outputs at reset values; after release, `o_empty`=4'b1111.
- Push 2,1,3 to ch1 on consecutive cycles, then pop ch1 three times → `o_data[1]` shows 2,1,3 in order; `o_count[1]` goes 1,2,3,2,1,0; other channels stay empty.
- Fill ch0 with 16 tags → `o_afull[0]` rises when count reaches 12; `o_full[0]`=1 at count 16.
  - 17th push alone → dropped, `o_ovf_err`=1.
  - Then push+pop in the same cycle → accepted, count stays 16, the new tag lands at the tail.
- Pop empty ch2 → `o_udf_err`=1, pointers unchanged; push to empty ch2 with same-cycle pop → count 1, no further error.
- Push 5 tags to ch3, assert `i_flush[3]` with a same-cycle push → count 0, `o_empty[3]`=1, pushed tag lost, no error.
- Run 40 push/pop cycles on ch1 with ≤16 in flight → ordering preserved across pointer wrap; random reset mid-run returns every output to its reset value on the next edge.
